// File: rtl/my_project_pkg.sv
// Shared types, network constants and the fixed-point reduce helper.
// MY_PROJECT_SATURATE_EN selects saturating rather than wrapping reduction.
package my_project_pkg;

  localparam int DATA_W = 18;
  localparam int FRAC_W = 10;
  localparam int ACC_W  = 40;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam logic [0:3][0:1][DATA_W-1:0] W1 = '{
    '{data_t'(1024),  data_t'(0)},
    '{data_t'(0),     data_t'(1024)},
    '{data_t'(1024),  data_t'(-1024)},
    '{data_t'(-1024), data_t'(1024)}
  };
  localparam logic [0:3][DATA_W-1:0] B1 = '0;

  localparam logic [0:0][0:3][DATA_W-1:0] W2 = '{
    '{data_t'(512), data_t'(512),
      data_t'(256), data_t'(256)}
  };
  localparam logic [0:0][DATA_W-1:0] B2 = '0;

  localparam acc_t SAT_MAX =
    acc_t'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam acc_t SAT_MIN =
    acc_t'(-(64'sd1 <<< (DATA_W-1)));

  function automatic data_t reduce(acc_t s);
    acc_t t;
    t = s >>> FRAC_W;
`ifdef MY_PROJECT_SATURATE_EN
    if (t > SAT_MAX)
      return data_t'(SAT_MAX[DATA_W-1:0]);
    else if (t < SAT_MIN)
      return data_t'(SAT_MIN[DATA_W-1:0]);
    else
      return t[DATA_W-1:0];
`else
    return t[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/my_project_if.sv
// Start/valid input and done/idle/ready output bundle.
// Same signal set in both MY_PROJECT_SATURATE_EN builds.
interface my_project_if;
  logic        ap_start;
  logic        input_2_V_ap_vld;
  logic [35:0] input_2_V;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [17:0] layer7_out_0_V;

  modport master (
    output ap_start, input_2_V_ap_vld, input_2_V,
    input  ap_done, ap_idle, ap_ready, layer7_out_0_V
  );

  modport slave (
    input  ap_start, input_2_V_ap_vld, input_2_V,
    output ap_done, ap_idle, ap_ready, layer7_out_0_V
  );
endinterface

// File: rtl/my_project_dense.sv
// Registered dense layer: y = reduce(W*x + B), optional ReLU.
// Reduction mode follows MY_PROJECT_SATURATE_EN via the package.
module my_project_dense
  import my_project_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter bit RELU  = 1'b0,
  parameter logic [0:N_OUT-1][0:N_IN-1][DATA_W-1:0] W = '0,
  parameter logic [0:N_OUT-1][DATA_W-1:0] B = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  input  logic [0:N_IN-1][DATA_W-1:0] x,
  output logic out_vld,
  output logic [0:N_OUT-1][DATA_W-1:0] y
);

  logic [0:N_OUT-1][DATA_W-1:0] y_d;
  acc_t  acc;
  data_t r;

  always_comb begin
    y_d = '0;
    acc = '0;
    r   = '0;
    for (int o = 0; o < N_OUT; o++) begin
      acc = acc_t'(data_t'(B[o])) <<< FRAC_W;
      for (int i = 0; i < N_IN; i++)
        acc = acc + acc_t'(data_t'(W[o][i]))
                  * acc_t'(data_t'(x[i]));
      r = reduce(acc);
      if (RELU && r < 0)
        r = '0;
      y_d[o] = r;
    end
  end

  // Data only moves on a valid beat so outputs hold between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      y       <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld)
        y <= y_d;
    end
  end

endmodule

// File: rtl/my_project.sv
// 2->4->1 fixed-point MLP, II=1, ap_done three edges after accept.
// Define MY_PROJECT_SATURATE_EN for saturating layer reduction.
module my_project
  import my_project_pkg::*;
(
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  my_project_if.slave  io
);

  logic acc_in;
  logic v0;
  logic v1;
  logic done;
  logic [0:1][DATA_W-1:0] x_q;
  logic [0:3][DATA_W-1:0] h;
  logic [0:0][DATA_W-1:0] y;

  assign acc_in = io.ap_start & io.input_2_V_ap_vld;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v0  <= 1'b0;
      x_q <= '0;
    end else begin
      v0 <= acc_in;
      if (acc_in) begin
        x_q[0] <= io.input_2_V[17:0];
        x_q[1] <= io.input_2_V[35:18];
      end
    end
  end

  my_project_dense #(
    .N_IN (2),
    .N_OUT(4),
    .RELU (1'b1),
    .W    (W1),
    .B    (B1)
  ) u_l1 (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .in_vld (v0),
    .x      (x_q),
    .out_vld(v1),
    .y      (h)
  );

  my_project_dense #(
    .N_IN (4),
    .N_OUT(1),
    .RELU (1'b0),
    .W    (W2),
    .B    (B2)
  ) u_l2 (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .in_vld (v1),
    .x      (h),
    .out_vld(done),
    .y      (y)
  );

  assign io.ap_ready       = acc_in;
  assign io.ap_idle        = ~acc_in & ~v0 & ~v1;
  assign io.ap_done        = done;
  assign io.layer7_out_0_V = y[0];

endmodule

// File: tb/tb_my_project.sv
// Scoreboard bench for my_project: directed vectors plus random ones.
// Expected overflow result follows MY_PROJECT_SATURATE_EN.
module tb_my_project;

  logic ap_clk = 1'b0;
  logic ap_rst_n;

  always #5 ap_clk = ~ap_clk;

  my_project_if io ();

  my_project dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .io      (io)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int last_acc = 0;
  int sb[$];
  int done_cyc[$];

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint red(input longint s);
    longint t;
    t = s >>> 10;
`ifdef MY_PROJECT_SATURATE_EN
    if (t > 131071) t = 131071;
    if (t < -131072) t = -131072;
`else
    t = t & 64'h3FFFF;
    if (t >= 131072) t = t - 262144;
`endif
    return t;
  endfunction

  function automatic longint relu(input longint v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int model(input int x0, input int x1);
    longint h0, h1, h2, h3;
    h0 = relu(red(1024 * longint'(x0)));
    h1 = relu(red(1024 * longint'(x1)));
    h2 = relu(red(1024 * longint'(x0) - 1024 * longint'(x1)));
    h3 = relu(red(1024 * longint'(x1) - 1024 * longint'(x0)));
    return int'(red(512 * h0 + 512 * h1 + 256 * h2 + 256 * h3));
  endfunction

  always @(posedge ap_clk) cyc++;

  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1 && io.ap_done === 1'b1) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0)
        check("spurious_done", 1, 0);
      else
        check("y", $signed(io.layer7_out_0_V), sb.pop_front());
    end
  end

  task automatic send(input int x0, input int x1, input bit vld,
                      input int exp);
    @(posedge ap_clk);
    #1;
    io.ap_start = 1'b1;
    io.input_2_V_ap_vld = vld;
    io.input_2_V = {18'(x1), 18'(x0)};
    if (vld) begin
      sb.push_back(exp);
      last_acc = cyc + 1;
    end
    #1 check("ap_ready", io.ap_ready, vld);
  endtask

  task automatic stop();
    @(posedge ap_clk);
    #1;
    io.ap_start = 1'b0;
    io.input_2_V_ap_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(posedge ap_clk);
    check("drain", sb.size(), 0);
    #1 check("idle_after", io.ap_idle, 1);
  endtask

  int ov_exp;
  int nd;
  int rx0, rx1;

  initial begin
`ifdef MY_PROJECT_SATURATE_EN
    ov_exp = 98303;
`else
    ov_exp = 65535;
`endif
    io.ap_start = 1'b0;
    io.input_2_V_ap_vld = 1'b0;
    io.input_2_V = '0;
    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    #1;
    check("rst_out", io.layer7_out_0_V, 0);
    check("rst_done", io.ap_done, 0);
    check("rst_idle", io.ap_idle, 1);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;

    // single vector with latency check
    send(1024, 2048, 1'b1, 1792);
    stop();
    drain();
    check("latency", done_cyc[done_cyc.size()-1], last_acc + 2);

    send(-3072, 1024, 1'b1, 1536);
    stop();
    drain();

    // two accepts separated by one bubble
    send(1024, 2048, 1'b1, 1792);
    send(0, 0, 1'b0, 0);
    send(-3072, 1024, 1'b1, 1536);
    stop();
    drain();
    check("done_gap",
          done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 2);

    send(131071, -131072, 1'b1, ov_exp);
    stop();
    drain();

    // start held with no valid data
    nd = n_done;
    repeat (5) send(777, -777, 1'b0, 0);
    repeat (4) @(posedge ap_clk);
    stop();
    #1;
    check("bubble_no_done", n_done, nd);
    check("bubble_hold", $signed(io.layer7_out_0_V), ov_exp);

    // random streaming vectors against the model
    for (int k = 0; k < 8; k++) begin
      rx0 = int'($urandom_range(0, 16384)) - 8192;
      rx1 = int'($urandom_range(0, 16384)) - 8192;
      send(rx0, rx1, 1'b1, model(rx0, rx1));
    end
    stop();
    drain();

    // reset with results in flight
    send(1024, 2048, 1'b1, 1792);
    send(-3072, 1024, 1'b1, 1536);
    stop();
    nd = n_done;
    @(posedge ap_clk);
    #3 ap_rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out", io.layer7_out_0_V, 0);
    check("midrst_done", io.ap_done, 0);
    check("midrst_idle", io.ap_idle, 1);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    repeat (6) @(posedge ap_clk);
    #1;
    check("midrst_no_done", n_done, nd);
    check("midrst_out_hold", io.layer7_out_0_V, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/my_project.md
Name: my_project

Overview:
- Fixed-point inference core: two-input, one-output multilayer perceptron (dense 2->4, ReLU, dense 4->1).
- Sits downstream of the input normalisation stage, which packs two 18-bit normalised samples into one 36-bit word.
- Fully pipelined, II=1, fixed latency; HLS-style ap_start/ap_done control.

Parameters:
- DATA_W, 18, width of every activation, weight and output (signed two's complement).
- FRAC_W, 10, fractional bits; format Q7.10, range -128.0 .. +127.999.
- ACC_W, 40, accumulator width for products and sums.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  request to accept an input.
- input_2_V_ap_vld  in  1  input word valid.
- input_2_V  in  36  [17:0]=x0, [35:18]=x1, each signed Q7.10.
- ap_done  out  1  one-cycle pulse: layer7_out_0_V updated this cycle.
- ap_idle  out  1  high when no input is accepted this cycle and the pipeline is empty.
- ap_ready  out  1  input accepted this cycle.
- layer7_out_0_V  out  18  network output y, signed Q7.10.

Behaviour:
- Reset (async assert, sync release): pipeline valids=0, all data regs=0, layer7_out_0_V=0, ap_done=0; ap_idle=1 while ap_start=0.
- Accept: acc = ap_start & input_2_V_ap_vld. ap_ready = acc (combinational). With ap_start=1 and vld=0, nothing is accepted and a bubble enters the pipeline; no stall.
- Stage 0 (edge T, acc=1): register x0, x1; v0<=1. Otherwise v0<=0 and data is held.
- Stage 1 (edge T+1): h_j = ReLU(sat(W1[j][0]*x0 + W1[j][1]*x1 + B1[j])), j=0..3; v1<=v0.
- Stage 2 (edge T+2): y = sat(sum_j W2[j]*h_j + B2); layer7_out_0_V<=y, ap_done<=v1.
- Latency: ap_done is high during the cycle after edge T+2. Back-to-back accepts produce back-to-back dones in order.
- Output holds its last value between dones.
- Weights, Q7.10 real values:
  - W1 = [[1,0],[0,1],[1,-1],[-1,1]], B1 = 0.
  - W2 = [0.5, 0.5, 0.25, 0.25], B2 = 0.
- Arithmetic:
  - Each product is a full-width DATA_W x DATA_W signed product (Q.20); biases are shifted left by FRAC_W before summing.
  - Sum in ACC_W bits, then arithmetic shift right FRAC_W (truncate toward -inf).
  - Result is reduced to DATA_W per the optional-feature rule, then ReLU is applied (hidden layer only).
- ap_idle = ~acc & ~v0 & ~v1.
- Reset mid-operation: in-flight results are discarded, no ap_done.

Optional Feature:
- Macro MY_PROJECT_SATURATE_EN.
- Defined: reduction to DATA_W saturates to [-131072, 131071].
- Undefined: reduction keeps the low DATA_W bits (wrap-around).
- Latency and interface are identical in both builds.

Decomposition:
- Package my_project_pkg holds:
  - DATA_W, FRAC_W and ACC_W.
  - typedef data_t (signed DATA_W) and acc_t (signed ACC_W).
  - W1/B1/W2/B2 constant arrays.
  - Reduce (shift + sat/wrap) function.
- One sub-module my_project_dense(N_IN, N_OUT, RELU): a registered dense layer, instantiated twice.

Test Plan:
- Reset: ap_rst_n=0 mid-run -> layer7_out_0_V=0, ap_done=0, ap_idle=1 immediately (async).
- x0=1.0 (1024), x1=2.0 (2048), accepted at edge T -> ap_done after edge T+2, y=1792 (1.75); ap_ready=1 in the accept cycle.
- x0=-3.0 (-3072), x1=1.0 (1024) -> y=1536 (1.5).
- Back-to-back accepts of the two vectors above with one vld=0 bubble between them:
  - Outputs arrive in order, 1792 then 1536.
  - The done pulses are separated by one idle cycle.
- x0=131071, x1=-131072, overflow case:
  - With MY_PROJECT_SATURATE_EN, y=98303.
  - Without it, h2 wraps to -1, ReLU gives 0, and y=65535.
- ap_start=1 with input_2_V_ap_vld=0 for 5 cycles -> ap_ready=0, no ap_done, output unchanged.
